jtdsp16_cendiv: RTL and testbench

- Parametrised clock-enable divider with external-access wait-state control for the DSP16 core.
- Divides the incoming cen strobe by DIV to produce the core enable cendiv, plus a mid-cycle phase strobe cendiv_ph.
- Inserts programmable fixed wait states, then holds for an ext_rq/ext_ok handshake, with an optional timeout that releases a hung access.
- Sits between the system clock-enable generator and every cendiv consumer: core pipeline and synchronous RAMs.

---
 rtl/jtdsp16_cendiv.sv | 116 +++++++++++
 tb/tb_jtdsp16_cendiv.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_cendiv.sv
// Clock-enable divider for the DSP16 core with external-access wait states.
// A fixed wait-state count is followed by an ext_rq/ext_ok handshake, with an optional timeout.
module jtdsp16_cendiv #(
   parameter int DIV   = 2,
   parameter int WAITW = 4,
   parameter int TOUT  = 0,
   parameter int TOUTW = 8
) (
   input  logic             rst,
   input  logic             clk,
   input  logic             cen,
   input  logic [WAITW-1:0] wstates,
   input  logic             ext_rq,
   input  logic             ext_ok,
   output logic             cendiv,
   output logic             cendiv_ph,
   output logic             stall,
   output logic             tout
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]    CLAST = CW'(DIV - 1);
   localparam logic [CW-1:0]    CHALF = CW'(DIV / 2 - 1);
   localparam logic [TOUTW-1:0] TLAST = (TOUT == 0) ? '0 : TOUTW'(TOUT - 1);
   localparam logic [WAITW-1:0] WONE  = WAITW'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD, ST_ABORT} state_t;

   state_t           r_st;
   logic [CW-1:0]    r_cnt;
   logic [WAITW-1:0] r_wcnt;
   logic [TOUTW-1:0] r_tcnt;
   logic             r_rq_l;

   logic w_rise, w_entry, w_hold, w_adv;

   // In HOLD the stall releases in the same clk as ext_ok, so that cen is not lost
   always_comb begin
      w_rise  = ext_rq & ~r_rq_l;
      w_entry = (r_st == ST_IDLE) & ((ext_rq & ~ext_ok) | (w_rise & (|wstates)));
      w_hold  = w_entry | (r_st == ST_WAIT) | ((r_st == ST_HOLD) & ext_rq & ~ext_ok);
      w_adv   = cen & ~w_hold;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_st      <= ST_IDLE;
         r_cnt     <= '0;
         r_wcnt    <= '0;
         r_tcnt    <= '0;
         r_rq_l    <= 1'b0;
         cendiv    <= 1'b0;
         cendiv_ph <= 1'b0;
         stall     <= 1'b0;
         tout      <= 1'b0;
      end else begin
         r_rq_l    <= ext_rq;
         cendiv    <= w_adv && (r_cnt == CLAST);
         cendiv_ph <= w_adv && (r_cnt == CHALF);
         tout      <= 1'b0;
         if (w_adv) r_cnt <= (r_cnt == CLAST) ? '0 : r_cnt + 1'b1;
         case (r_st)
            ST_IDLE: begin
               if (w_entry) begin
                  stall <= 1'b1;
                  if (|wstates) begin
                     r_st   <= ST_WAIT;
                     r_wcnt <= wstates;
                  end else begin
                     r_st   <= ST_HOLD;
                     r_tcnt <= '0;
                  end
               end
            end
            ST_WAIT: begin
               if (!ext_rq) begin
                  r_st  <= ST_IDLE;
                  stall <= 1'b0;
               end else if (cen) begin
                  r_wcnt <= r_wcnt - 1'b1;
                  if (r_wcnt == WONE) begin
                     if (ext_ok) begin
                        r_st  <= ST_IDLE;
                        stall <= 1'b0;
                     end else begin
                        r_st   <= ST_HOLD;
                        r_tcnt <= '0;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (ext_ok || !ext_rq) begin
                  r_st  <= ST_IDLE;
                  stall <= 1'b0;
               end else if (cen) begin
                  r_tcnt <= r_tcnt + 1'b1;
                  if (TOUT != 0 && r_tcnt == TLAST) begin
                     r_st  <= ST_ABORT;
                     stall <= 1'b0;
                     tout  <= 1'b1;
                  end
               end
            end
            ST_ABORT: begin
               if (!ext_rq) r_st <= ST_IDLE;
            end
            default: begin
               r_st  <= ST_IDLE;
               stall <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtdsp16_cendiv.sv
// Bench for jtdsp16_cendiv: two parameter sets driven by shared stimulus,
// compared every clk against a tick-level behavioural model.
module tb_jtdsp16_cendiv;

   logic       clk, rst, cen, ext_rq, ext_ok;
   logic [3:0] wstates;
   logic       o0_cd, o0_ph, o0_st, o0_to;
   logic       o1_cd, o1_ph, o1_st, o1_to;

   int n_tests = 0;
   int n_fail  = 0;

   jtdsp16_cendiv #(.DIV(2), .WAITW(4), .TOUT(0), .TOUTW(8)) u0 (
      .rst(rst), .clk(clk), .cen(cen), .wstates(wstates),
      .ext_rq(ext_rq), .ext_ok(ext_ok),
      .cendiv(o0_cd), .cendiv_ph(o0_ph), .stall(o0_st), .tout(o0_to)
   );

   jtdsp16_cendiv #(.DIV(4), .WAITW(4), .TOUT(5), .TOUTW(8)) u1 (
      .rst(rst), .clk(clk), .cen(cen), .wstates(wstates),
      .ext_rq(ext_rq), .ext_ok(ext_ok),
      .cendiv(o1_cd), .cendiv_ph(o1_ph), .stall(o1_st), .tout(o1_to)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // mode: 0 free-running, 1 counting wait ticks, 2 waiting for ok, 3 timed out
   typedef struct {
      int phase;
      int mode;
      int wleft;
      int held;
      bit rq_d;
      bit cd;
      bit ph;
      bit st;
      bit to;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t mdl_reset();
      mdl_t n;
      n.phase = 0; n.mode = 0; n.wleft = 0; n.held = 0;
      n.rq_d = 0; n.cd = 0; n.ph = 0; n.st = 0; n.to = 0;
      return n;
   endfunction

   function automatic mdl_t step(input mdl_t m, input int div, input int tmo,
                                 input bit c, input int ws, input bit rq, input bit ok);
      mdl_t n = m;
      bit start   = 0;
      bit blocked = 0;
      bit adv;
      case (m.mode)
         0: begin
            start   = (rq && !ok) || (rq && !m.rq_d && ws != 0);
            blocked = start;
         end
         1: blocked = 1;
         2: blocked = rq && !ok;
         default: blocked = 0;
      endcase
      adv  = c && !blocked;
      n.cd = adv && (m.phase == div - 1);
      n.ph = adv && (m.phase == div / 2 - 1);
      if (adv) n.phase = (m.phase + 1) % div;
      n.to = 0;
      case (m.mode)
         0: if (start) begin
               if (ws != 0) begin n.mode = 1; n.wleft = ws; end
               else begin n.mode = 2; n.held = 0; end
            end
         1: if (!rq) n.mode = 0;
            else if (c) begin
               if (m.wleft == 1) begin n.mode = ok ? 0 : 2; n.held = 0; end
               else n.wleft = m.wleft - 1;
            end
         2: if (ok || !rq) n.mode = 0;
            else if (c) begin
               n.held = m.held + 1;
               if (tmo != 0 && n.held == tmo) begin n.mode = 3; n.to = 1; end
            end
         default: if (!rq) n.mode = 0;
      endcase
      n.st   = (n.mode == 1) || (n.mode == 2);
      n.rq_d = rq;
      return n;
   endfunction

   task automatic chk(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Starts and ends at a negedge: drive, clock, advance models, compare.
   task automatic cycle(input bit c, input int ws, input bit rq, input bit ok);
      cen = c; wstates = 4'(ws); ext_rq = rq; ext_ok = ok;
      @(posedge clk);
      m0 = step(m0, 2, 0, c, ws, rq, ok);
      m1 = step(m1, 4, 5, c, ws, rq, ok);
      #1;
      chk("u0.cendiv", o0_cd, m0.cd);
      chk("u0.cendiv_ph", o0_ph, m0.ph);
      chk("u0.stall", o0_st, m0.st);
      chk("u0.tout", o0_to, m0.to);
      chk("u1.cendiv", o1_cd, m1.cd);
      chk("u1.cendiv_ph", o1_ph, m1.ph);
      chk("u1.stall", o1_st, m1.st);
      chk("u1.tout", o1_to, m1.to);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst.u0.cendiv", o0_cd, 1'b0);
      chk("rst.u0.cendiv_ph", o0_ph, 1'b0);
      chk("rst.u0.stall", o0_st, 1'b0);
      chk("rst.u0.tout", o0_to, 1'b0);
      chk("rst.u1.cendiv", o1_cd, 1'b0);
      chk("rst.u1.cendiv_ph", o1_ph, 1'b0);
      chk("rst.u1.stall", o1_st, 1'b0);
      chk("rst.u1.tout", o1_to, 1'b0);
      m0 = mdl_reset();
      m1 = mdl_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int first, tot0, tot1, cd0, st0, st1;
      bit rq_v, ok_v;
      int ws_v;
      rst = 1'b0; cen = 1'b0; wstates = '0; ext_rq = 1'b0; ext_ok = 1'b0;
      @(negedge clk);
      do_reset();

      // free-running divide with cen every clk
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 0, 0);
         chk("lit.u0.ph", o0_ph, (i % 2) == 0);
         chk("lit.u0.cd", o0_cd, (i % 2) == 1);
         chk("lit.u1.ph", o1_ph, (i % 4) == 1);
         chk("lit.u1.cd", o1_cd, (i % 4) == 3);
         chk("lit.u0.st", o0_st, 1'b0);
      end

      // three wait states with ext_ok already high
      do_reset();
      st0 = 0; st1 = 0; cd0 = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1, 3, 1, 1);
         st0 += o0_st; st1 += o1_st; cd0 += o0_cd;
      end
      chk_int("lit.u0.wait_stall_clks", st0, 3);
      chk_int("lit.u1.wait_stall_clks", st1, 3);
      chk_int("lit.u0.wait_cendiv_cnt", cd0, 1);
      cycle(1, 3, 0, 1);

      // hung access: timeout on u1 only
      do_reset();
      first = -1; tot0 = 0; tot1 = 0; cd0 = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle(1, 0, 1, 0);
         if (o1_to && first < 0) first = i;
         tot0 += o0_to; tot1 += o1_to; cd0 += o0_cd;
      end
      chk_int("lit.u1.tout_clk", first, 6);
      chk_int("lit.u1.tout_count", tot1, 1);
      chk_int("lit.u0.tout_count", tot0, 0);
      chk_int("lit.u0.cendiv_in_hold", cd0, 0);
      chk("lit.u1.abort_no_stall", o1_st, 1'b0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 0);
      chk("lit.u1.restall", o1_st, 1'b1);
      chk("lit.u0.restall", o0_st, 1'b1);

      // reset in the middle of a hold, with the divider part way through
      do_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 0);
      cycle(1, 0, 1, 0);
      do_reset();
      cycle(1, 0, 0, 0);
      chk("lit.u0.ph_after_rst", o0_ph, 1'b1);
      chk("lit.u0.cd_after_rst", o0_cd, 1'b0);

      // randomized traffic
      rq_v = 0; ok_v = 0; ws_v = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) rq_v = !rq_v;
         if ($urandom_range(0, 5) == 0) ok_v = !ok_v;
         if ($urandom_range(0, 19) == 0)
            ws_v = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
         if ($urandom_range(0, 599) == 0) do_reset();
         cycle($urandom_range(0, 2) != 0, ws_v, rq_v, ok_v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
